// File: rtl/imem_loader.sv
// imem_loader: encodes symbolic LEGv8 instructions (LDUR, STUR, CBZ, ADD,
// SUB, AND, ORR) and writes them to consecutive instruction-memory words
// starting at address 0. Input uses a valid/ready handshake. Each write
// appears one cycle after the transfer that produced it.
module imem_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [4:0]        rd,
  input  logic [4:0]        rn,
  input  logic [4:0]        rm,
  input  logic [18:0]       imm,
  input  logic              last,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_LDUR = 3'd0,
    OP_STUR = 3'd1,
    OP_CBZ  = 3'd2,
    OP_ADD  = 3'd3,
    OP_SUB  = 3'd4,
    OP_AND  = 3'd5,
    OP_ORR  = 3'd6,
    OP_INV  = 3'd7
  } op_t;

  // count value meaning "memory full", and the value one below it
  localparam logic [ADDR_W:0] FULL  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LASTW = {1'b0, {ADDR_W{1'b1}}};

  state_t            state, state_nx;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       enc;
  logic              xfer;
  logic              op_ok;

  assign busy     = (state == LOAD);
  assign done     = (state == DONE);
  assign in_ready = (state == LOAD) && (count < FULL) && !start;
  assign xfer     = in_valid && in_ready;
  assign op_ok    = (op != OP_INV);

  // Encode the presented instruction; only fields used by the op reach wdata
  always_comb begin
    enc = '0;
    case (op_t'(op))
      OP_LDUR: enc = {11'b11111000010, imm[8:0], 2'b00, rn, rd};
      OP_STUR: enc = {11'b11111000000, imm[8:0], 2'b00, rn, rd};
      OP_CBZ:  enc = {8'b10110100, imm, rd};
      OP_ADD:  enc = {11'b10001011000, rm, 6'b000000, rn, rd};
      OP_SUB:  enc = {11'b11001011000, rm, 6'b000000, rn, rd};
      OP_AND:  enc = {11'b10001010000, rm, 6'b000000, rn, rd};
      OP_ORR:  enc = {11'b10101010000, rm, 6'b000000, rn, rd};
      default: enc = '0;
    endcase
  end

  // Next-state logic: start always (re)enters LOAD; LOAD ends on last or full
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = LOAD;
      LOAD: begin
        if (start) begin
          state_nx = LOAD;
        end else if (xfer && (last || (op_ok && count == LASTW))) begin
          state_nx = DONE;
        end
      end
      DONE: if (start) state_nx = LOAD;
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Write port, pointer, word count and sticky error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr   <= '0;
      count <= '0;
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      err   <= 1'b0;
    end else begin
      we <= 1'b0;
      if (start) begin
        ptr   <= '0;
        count <= '0;
        err   <= 1'b0;
      end else if (xfer) begin
        if (!op_ok) begin
          err <= 1'b1;
        end else begin
          we    <= 1'b1;
          waddr <= ptr;
          wdata <= enc;
          ptr   <= ptr + 1'b1;
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized checks of imem_loader against a
// transaction-level model (expected write list, word count, error flag).
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  op = '0;
  logic [4:0]  rd = '0, rn = '0, rm = '0;
  logic [18:0] imm = '0;
  logic        last = 1'b0;

  logic        in_ready, we, busy, done, err;
  logic [5:0]  waddr;
  logic [31:0] wdata;
  logic [6:0]  count;

  logic        s_in_ready, s_we, s_busy, s_done, s_err;
  logic [1:0]  s_waddr;
  logic [31:0] s_wdata;
  logic [2:0]  s_count;

  int checks = 0;
  int errors = 0;

  // model state: 0 idle, 1 loading, 2 finished
  int mst = 0, mcount = 0, mdepth = 64;
  bit merr = 0;
  int ma[$];
  logic [31:0] md[$];
  // captured DUT writes
  int wa[$], sa[$];
  logic [31:0] wd[$], sd[$];

  imem_loader #(.ADDR_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd(rd), .rn(rn), .rm(rm), .imm(imm), .last(last),
    .we(we), .waddr(waddr), .wdata(wdata), .count(count),
    .busy(busy), .done(done), .err(err)
  );

  imem_loader #(.ADDR_W(2)) dut_small (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
    .op(op), .rd(rd), .rn(rn), .rm(rm), .imm(imm), .last(last),
    .we(s_we), .waddr(s_waddr), .wdata(s_wdata), .count(s_count),
    .busy(s_busy), .done(s_done), .err(s_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset) begin
      if (we)   begin wa.push_back(int'(waddr));   wd.push_back(wdata);   end
      if (s_we) begin sa.push_back(int'(s_waddr)); sd.push_back(s_wdata); end
    end
  end

  function automatic logic [31:0] enc_model(input int o, input int d, input int n,
                                            input int m, input int i);
    longint w;
    case (o)
      0: w = 64'h7C2 * 2097152 + (i % 512) * 4096 + n * 32 + d;
      1: w = 64'h7C0 * 2097152 + (i % 512) * 4096 + n * 32 + d;
      2: w = 64'hB4 * 16777216 + i * 32 + d;
      3: w = 64'h458 * 2097152 + m * 65536 + n * 32 + d;
      4: w = 64'h658 * 2097152 + m * 65536 + n * 32 + d;
      5: w = 64'h450 * 2097152 + m * 65536 + n * 32 + d;
      6: w = 64'h550 * 2097152 + m * 65536 + n * 32 + d;
      default: w = 0;
    endcase
    return w[31:0];
  endfunction

  function automatic bit exp_ready();
    return (mst == 1) && (mcount < mdepth) && !start;
  endfunction

  task automatic clear_all();
    mst = 0; mcount = 0; merr = 0;
    ma.delete(); md.delete();
    wa.delete(); wd.delete(); sa.delete(); sd.delete();
  endtask

  task automatic drive(input bit s, input bit v, input int o, input int d,
                       input int n, input int m, input int i, input bit l);
    start = s; in_valid = v; op = 3'(o);
    rd = 5'(d); rn = 5'(n); rm = 5'(m); imm = 19'(i); last = l;
  endtask

  // advance one clock; model consumes the inputs presented before the edge
  task automatic tick();
    bit acc;
    acc = (mst == 1) && !start && in_valid && (mcount < mdepth);
    if (start) begin
      mst = 1; mcount = 0; merr = 0;
    end else if (acc) begin
      if (op == 3'd7) merr = 1;
      else begin
        ma.push_back(mcount);
        md.push_back(enc_model(int'(op), int'(rd), int'(rn), int'(rm), int'(imm)));
        mcount++;
      end
      if (last || mcount == mdepth) mst = 2;
    end
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(0, 1, 3, 1, 1, 1, 0, 0);
    #3;
    checks++;
    if ({we, waddr, wdata, count, err} !== '0) begin
      errors++;
      $display("FAIL reset_regs: we=%0b waddr=%0h wdata=%0h count=%0d err=%0b, required all 0",
               we, waddr, wdata, count, err);
    end
    checks++;
    if ({in_ready, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: ready/busy/done=%b required 000", {in_ready, busy, done});
    end
    @(negedge clk);
    reset = 1'b1;
    clear_all();
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_ready: got %0b required 0", in_ready);
    end
    tick();
    checks++;
    if (we !== 1'b0 || count !== 7'd0) begin
      errors++;
      $display("FAIL idle_ignores_valid: we=%0b count=%0d required 0/0", we, count);
    end
  endtask

  task automatic test_encode();
    int          o[7]  = '{0, 1, 3, 4, 5, 6, 2};
    int          d[7]  = '{1, 5, 3, 3, 3, 3, 0};
    int          n[7]  = '{2, 0, 1, 1, 1, 1, 0};
    int          m[7]  = '{0, 0, 2, 2, 2, 2, 0};
    int          iv[7] = '{8, 0, 0, 0, 0, 0, 'h7FFFE};
    logic [31:0] ew[7] = '{32'hF8408041, 32'hF8000005, 32'h8B020023, 32'hCB020023,
                           32'h8A020023, 32'hAA020023, 32'hB4FFFFC0};
    clear_all();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (busy !== 1'b1 || count !== 7'd0) begin
      errors++;
      $display("FAIL start_load: busy=%0b count=%0d required 1/0", busy, count);
    end
    for (int k = 0; k < 7; k++) begin
      drive(0, 1, o[k], d[k], n[k], m[k], iv[k], k == 6);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL enc_ready[%0d]: got %0b required 1", k, in_ready);
      end
      tick();
      checks++;
      if (we !== 1'b1 || waddr !== 6'(k) || wdata !== ew[k]) begin
        errors++;
        $display("FAIL enc_word[%0d]: we=%0b addr=%0d data=%08h required 1/%0d/%08h",
                 k, we, waddr, wdata, k, ew[k]);
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL enc_done: done=%0b busy=%0b ready=%0b required 1/0/0", done, busy, in_ready);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (we !== 1'b0 || count !== 7'd7 || done !== 1'b1) begin
      errors++;
      $display("FAIL enc_after: we=%0b count=%0d done=%0b required 0/7/1", we, count, done);
    end
    checks++;
    if (wd.size() != md.size() || wd != md || wa != ma) begin
      errors++;
      $display("FAIL enc_model: got %0d writes required %0d matching model", wd.size(), md.size());
    end
  endtask

  task automatic test_fields();
    logic [31:0] ew[4] = '{32'h8B020023, 32'hF8508041, 32'hF81FF005, 32'hB4000000};
    clear_all();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 3, 3, 1, 2, 'h7FFFF, 0); tick();
    drive(0, 1, 0, 1, 2, 31, 'h7FF08, 0); tick();
    drive(0, 1, 1, 5, 0, 31, 'h7FFFF, 0); tick();
    drive(0, 1, 2, 0, 31, 31, 0, 1);      tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);        tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= wd.size() || wd[k] !== ew[k] || wd[k] !== md[k]) begin
        errors++;
        $display("FAIL field_iso[%0d]: got %08h required %08h",
                 k, (k < wd.size()) ? wd[k] : 32'hx, ew[k]);
      end
    end
  endtask

  task automatic test_full();
    clear_all();
    mdepth = 4;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 3, k, 1, 2, 0, 0);
      #1;
      checks++;
      if (s_in_ready !== (k < 4)) begin
        errors++;
        $display("FAIL full_ready[%0d]: got %0b required %0b", k, s_in_ready, k < 4);
      end
      tick();
      if (k == 3) begin
        checks++;
        if (s_done !== 1'b1 || s_count !== 3'd4 || s_waddr !== 2'd3 || s_we !== 1'b1) begin
          errors++;
          $display("FAIL full_done: done=%0b count=%0d addr=%0d we=%0b required 1/4/3/1",
                   s_done, s_count, s_waddr, s_we);
        end
      end
    end
    checks++;
    if (s_we !== 1'b0 || s_count !== 3'd4 || s_count !== 3'(mcount)) begin
      errors++;
      $display("FAIL full_fifth: we=%0b count=%0d required 0/4", s_we, s_count);
    end
    checks++;
    if (sa.size() != 4 || sa != ma || sd != md) begin
      errors++;
      $display("FAIL full_writes: got %0d writes required 4 at addr 0..3", sa.size());
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    mdepth = 64;
  endtask

  task automatic test_invalid();
    clear_all();
    drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 3, 1, 1, 2, 0, 0); tick();
    drive(0, 1, 7, 2, 2, 2, 0, 0); tick();
    checks++;
    if (we !== 1'b0 || err !== 1'b1 || count !== 7'd1) begin
      errors++;
      $display("FAIL inv_consume: we=%0b err=%0b count=%0d required 0/1/1", we, err, count);
    end
    drive(0, 1, 3, 3, 1, 2, 0, 1); tick();
    checks++;
    if (we !== 1'b1 || waddr !== 6'd1 || done !== 1'b1 || err !== 1'b1) begin
      errors++;
      $display("FAIL inv_second_add: we=%0b addr=%0d done=%0b err=%0b required 1/1/1/1",
               we, waddr, done, err);
    end
    checks++;
    if (wa != ma || wd != md || wa.size() != 2) begin
      errors++;
      $display("FAIL inv_writes: got %0d writes required 2", wa.size());
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
    checks++;
    if (err !== 1'b0 || count !== 7'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL inv_restart: err=%0b count=%0d busy=%0b required 0/0/1", err, count, busy);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    clear_all();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int k = 0; k < 300; k++) begin
      drive($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 85, $urandom_range(0, 7),
            $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
            $urandom_range(0, 'h7FFFF), $urandom_range(0, 99) < 4);
      #1;
      checks++;
      if (in_ready !== exp_ready()) begin
        errors++;
        $display("FAIL rnd_ready[%0d]: got %0b required %0b", k, in_ready, exp_ready());
      end
      tick();
      checks++;
      if (count !== 7'(mcount) || err !== merr || busy !== (mst == 1) || done !== (mst == 2)) begin
        errors++;
        $display("FAIL rnd_state[%0d]: count=%0d err=%0b busy=%0b done=%0b required %0d/%0b/%0b/%0b",
                 k, count, err, busy, done, mcount, merr, mst == 1, mst == 2);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (wa != ma || wd != md) begin
      errors++;
      $display("FAIL rnd_writes: got %0d writes required %0d matching model", wd.size(), md.size());
    end
  endtask

  task automatic test_reset_midload();
    clear_all();
    drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 4, 7, 8, 9, 0, 0); tick();
    drive(0, 1, 4, 7, 8, 9, 0, 0); tick();
    checks++;
    if (we !== 1'b1 || count !== 7'd2) begin
      errors++;
      $display("FAIL pre_reset: we=%0b count=%0d required 1/2", we, count);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (we !== 1'b0 || count !== 7'd0 || busy !== 1'b0 || done !== 1'b0 ||
        waddr !== 6'd0 || wdata !== 32'd0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: we=%0b count=%0d busy=%0b addr=%0d data=%08h required all 0",
               we, count, busy, waddr, wdata);
    end
    @(negedge clk);
    reset = 1'b1;
    clear_all();
    drive(0, 1, 3, 1, 1, 1, 0, 0);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_ready: got %0b required 0", in_ready);
    end
    tick();
    tick();
    checks++;
    if (we !== 1'b0 || busy !== 1'b0 || wa.size() != 0) begin
      errors++;
      $display("FAIL post_reset_idle: we=%0b busy=%0b writes=%0d required 0/0/0",
               we, busy, wa.size());
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_encode();
    test_fields();
    test_full();
    test_invalid();
    test_back_to_back();
    test_reset_midload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
